// File: rtl/bb_pkg.sv
// bb_pkg: shared baseband types for the ACL transmit scheduler
// Contents: tx_st_e FSM encoding, RETX_W_DEF default retransmit counter width
package bb_pkg;
  localparam int RETX_W_DEF = 4;
  typedef enum logic [1:0] {IDLE, TX, WAIT} tx_st_e;
endpackage

// File: rtl/acltx_sched_if.sv
// acltx_sched_if: host, rx-decoder and tx-timing signals of the ACL tx scheduler
// master: drives host/decoder/timing inputs and observes scheduler outputs
// slave:  the scheduler itself
interface acltx_sched_if #(parameter int RETX_W = bb_pkg::RETX_W_DEF);
  logic              bsm_load_p;
  logic [9:0]        bsm_len;
  logic              flush_p;
  logic [2:0]        ms_lt_addr;
  logic [7:0]        dec_arqn;
  logic [7:0]        dec_flow;
  logic              dec_hdr_p;
  logic              dec_hecgood;
  logic              header_st_p;
  logic              pk_encode;
  logic              py_endp;
  logic              ms_tslot_p;
  logic [RETX_W-1:0] regi_retx_limit;
  logic              s1a;
  logic              bsm_wrbuf;
  logic              bsm_wrrdy;
  logic [1:0]        txbuf_valid;
  logic [9:0]        tx_pylenByte;
  logic              tx_null;
  logic              tx_seqn;
  logic              txbuf_free_p;
  logic              drop_p;
  logic              load_err_p;
  modport master (
    output bsm_load_p, bsm_len, flush_p, ms_lt_addr, dec_arqn, dec_flow, dec_hdr_p,
           dec_hecgood, header_st_p, pk_encode, py_endp, ms_tslot_p, regi_retx_limit,
    input  s1a, bsm_wrbuf, bsm_wrrdy, txbuf_valid, tx_pylenByte, tx_null, tx_seqn,
           txbuf_free_p, drop_p, load_err_p
  );
  modport slave (
    input  bsm_load_p, bsm_len, flush_p, ms_lt_addr, dec_arqn, dec_flow, dec_hdr_p,
           dec_hecgood, header_st_p, pk_encode, py_endp, ms_tslot_p, regi_retx_limit,
    output s1a, bsm_wrbuf, bsm_wrrdy, txbuf_valid, tx_pylenByte, tx_null, tx_seqn,
           txbuf_free_p, drop_p, load_err_p
  );
endinterface

// File: rtl/acltx_bufslot.sv
// acltx_bufslot: loaded flag and payload length of one tx buffer
// Ports: clk_6M, rstz (sync active-low); load sets valid and latches len_in;
// clr clears valid; flush clears valid with priority; valid, len outputs
module acltx_bufslot (
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       load,
  input  logic       clr,
  input  logic       flush,
  input  logic [9:0] len_in,
  output logic       valid,
  output logic [9:0] len
);
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      valid <= 1'b0;
      len   <= '0;
    end else begin
      valid <= flush ? 1'b0 : load ? 1'b1 : clr ? 1'b0 : valid;
      len   <= (load && !flush) ? len_in : len;
    end
  end
endmodule

// File: rtl/acltx_sched.sv
// acltx_sched: ACL tx double-buffer scheduler with ARQN/SEQN retransmission
// Ports: clk_6M, rstz (sync active-low), b (acltx_sched_if.slave) carrying host
// load, rx ARQN/FLOW decode, tx timing strobes and buffer/SEQN status outputs
module acltx_sched
  import bb_pkg::*;
#(
  parameter int RETX_W = RETX_W_DEF
) (
  input logic            clk_6M,
  input logic            rstz,
  acltx_sched_if.slave   b
);
  tx_st_e            st;
  logic [RETX_W-1:0] retx;
  logic [RETX_W-1:0] retx_nx;
  logic              slot_seen;
  logic [1:0]        valid;
  logic [9:0]        len [2];
  logic              flow_ok, hdr_ok, ack, nak, lim, done, ld;
  assign b.bsm_wrbuf    = ~b.s1a;
  assign b.bsm_wrrdy    = ~valid[b.bsm_wrbuf];
  assign b.txbuf_valid  = valid;
  assign b.tx_pylenByte = len[b.s1a];
  assign flow_ok = b.dec_flow[b.ms_lt_addr];
  assign hdr_ok  = b.dec_hdr_p & b.dec_hecgood & b.dec_arqn[b.ms_lt_addr];
  assign ack     = (st == WAIT) & hdr_ok;
  // a missing reply is only declared once a second slot boundary passes in WAIT
  assign nak     = (st == WAIT) & (b.dec_hdr_p ? ~hdr_ok : b.ms_tslot_p & slot_seen);
  assign retx_nx = &retx ? retx : retx + RETX_W'(1);
  assign lim     = nak & (|b.regi_retx_limit) & (retx_nx == b.regi_retx_limit);
  assign done    = ack | lim;
  assign ld      = b.bsm_load_p & b.bsm_wrrdy & ~b.flush_p;
  for (genvar i = 0; i < 2; i++) begin : g_slot
    acltx_bufslot u_slot (
      .clk_6M (clk_6M),
      .rstz   (rstz),
      .load   (ld & (b.bsm_wrbuf == 1'(i))),
      .clr    (done & ~b.flush_p & (b.s1a == 1'(i))),
      .flush  (b.flush_p),
      .len_in (b.bsm_len),
      .valid  (valid[i]),
      .len    (len[i])
    );
  end
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      st             <= IDLE;
      retx           <= '0;
      slot_seen      <= 1'b0;
      b.s1a          <= 1'b0;
      b.tx_seqn      <= 1'b1;
      b.tx_null      <= 1'b1;
      b.txbuf_free_p <= 1'b0;
      b.drop_p       <= 1'b0;
      b.load_err_p   <= 1'b0;
    end else begin
      b.load_err_p   <= b.bsm_load_p & ~b.bsm_wrrdy;
      b.txbuf_free_p <= ack & ~b.flush_p;
      b.drop_p       <= lim & ~b.flush_p;
      if (b.flush_p) begin
        st        <= IDLE;
        retx      <= '0;
        b.tx_null <= 1'b1;
      end else begin
        case (st)
          IDLE: begin
            if (b.header_st_p && b.pk_encode) begin
              b.tx_null <= ~(flow_ok & valid[b.s1a]);
              st        <= (flow_ok & valid[b.s1a]) ? TX : IDLE;
            end
            // host can only fill the idle buffer, so hand it over when ours is empty
            if (!valid[b.s1a] && valid[~b.s1a]) b.s1a <= ~b.s1a;
          end
          TX: begin
            if (b.py_endp) begin
              st        <= WAIT;
              slot_seen <= 1'b0;
            end
          end
          WAIT: begin
            if (b.ms_tslot_p) slot_seen <= 1'b1;
            if (done) begin
              b.s1a     <= ~b.s1a;
              b.tx_seqn <= ~b.tx_seqn;
              retx      <= '0;
              st        <= IDLE;
            end else if (nak) begin
              retx <= retx_nx;
              st   <= IDLE;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_acltx_sched.sv
// tb_acltx_sched: self-checking bench for acltx_sched with a free/drop pulse scoreboard
module tb_acltx_sched;
  import bb_pkg::*;
  typedef struct {
    bit drop;
    bit s1a;
  } ev_t;
  logic clk_6M = 1'b0;
  logic rstz   = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  ev_t exp_q[$];
  ev_t mon_e;
  acltx_sched_if b ();
  acltx_sched u_dut (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .b      (b)
  );
  always #5 clk_6M = ~clk_6M;
  always @(negedge clk_6M) begin
    if (rstz && (b.txbuf_free_p || b.drop_p)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pulse_unexpected free=%0b drop=%0b", b.txbuf_free_p, b.drop_p);
      end else begin
        mon_e = exp_q.pop_front();
        if ({b.drop_p, b.txbuf_free_p, b.s1a} !== {mon_e.drop, ~mon_e.drop, mon_e.s1a}) begin
          miscompares++;
          $display("FAIL pulse_kind got drop/free/s1a=%b%b%b exp=%b%b%b", b.drop_p,
                   b.txbuf_free_p, b.s1a, mon_e.drop, ~mon_e.drop, mon_e.s1a);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask
  task automatic idle_inputs();
    b.bsm_load_p  = 1'b0;
    b.bsm_len     = '0;
    b.flush_p     = 1'b0;
    b.ms_lt_addr  = 3'd3;
    b.dec_arqn    = 8'h00;
    b.dec_flow    = 8'hFF;
    b.dec_hdr_p   = 1'b0;
    b.dec_hecgood = 1'b0;
    b.header_st_p = 1'b0;
    b.pk_encode   = 1'b0;
    b.py_endp     = 1'b0;
    b.ms_tslot_p  = 1'b0;
  endtask
  task automatic do_reset(input logic [3:0] limit);
    idle_inputs();
    b.regi_retx_limit = limit;
    rstz = 1'b0;
    repeat (2) tick();
    rstz = 1'b1;
    exp_q.delete();
  endtask
  task automatic do_load(input logic [9:0] l);
    b.bsm_load_p = 1'b1;
    b.bsm_len    = l;
    tick();
    b.bsm_load_p = 1'b0;
  endtask
  task automatic do_header(input bit fl);
    b.header_st_p = 1'b1;
    b.pk_encode   = 1'b1;
    b.dec_flow    = fl ? 8'hFF : 8'hF7;
    tick();
    b.header_st_p = 1'b0;
    b.pk_encode   = 1'b0;
    b.dec_flow    = 8'hFF;
  endtask
  task automatic do_endp();
    b.py_endp = 1'b1;
    tick();
    b.py_endp = 1'b0;
  endtask
  task automatic do_hdr(input bit hec, input bit arqn);
    b.dec_hdr_p   = 1'b1;
    b.dec_hecgood = hec;
    b.dec_arqn    = arqn ? 8'h08 : 8'hF7;
    tick();
    b.dec_hdr_p   = 1'b0;
    b.dec_hecgood = 1'b0;
    b.dec_arqn    = 8'h00;
  endtask
  task automatic do_slot();
    b.ms_tslot_p = 1'b1;
    tick();
    b.ms_tslot_p = 1'b0;
  endtask
  task automatic end_test(input string name);
    tick();
    tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending_pulses got=%0d exp=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask
  task automatic test_reset();
    do_reset(4'd0);
    vectors++;
    if ({b.s1a, b.tx_seqn, b.txbuf_valid, b.tx_null, b.bsm_wrbuf, b.bsm_wrrdy} !== 7'b0100111) begin
      miscompares++;
      $display("FAIL reset_state got=%b exp=0100111",
               {b.s1a, b.tx_seqn, b.txbuf_valid, b.tx_null, b.bsm_wrbuf, b.bsm_wrrdy});
    end
    vectors++;
    if ({b.tx_pylenByte, b.txbuf_free_p, b.drop_p, b.load_err_p} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_len_pulses got=%h exp=0",
               {b.tx_pylenByte, b.txbuf_free_p, b.drop_p, b.load_err_p});
    end
    do_load(10'd20);
    tick();
    do_header(1'b1);
    do_endp();
    rstz = 1'b0;
    b.dec_hdr_p   = 1'b1;
    b.dec_hecgood = 1'b1;
    b.dec_arqn    = 8'h08;
    tick();
    idle_inputs();
    tick();
    vectors++;
    if ({b.s1a, b.tx_seqn, b.txbuf_valid, b.tx_null, b.tx_pylenByte} !== {5'b01001, 10'd0}) begin
      miscompares++;
      $display("FAIL reset_midwait got=%b exp=%b",
               {b.s1a, b.tx_seqn, b.txbuf_valid, b.tx_null, b.tx_pylenByte}, {5'b01001, 10'd0});
    end
    rstz = 1'b1;
    end_test("reset");
  endtask
  task automatic test_ack_flow();
    do_reset(4'd0);
    do_load(10'd27);
    vectors++;
    if (b.txbuf_valid !== 2'b10) begin
      miscompares++;
      $display("FAIL ack_load_valid got=%b exp=10", b.txbuf_valid);
    end
    tick();
    vectors++;
    if ({b.s1a, b.bsm_wrbuf, b.bsm_wrrdy, b.tx_pylenByte} !== {3'b101, 10'd27}) begin
      miscompares++;
      $display("FAIL ack_handover got=%b exp=%b", {b.s1a, b.bsm_wrbuf, b.bsm_wrrdy, b.tx_pylenByte},
               {3'b101, 10'd27});
    end
    do_header(1'b1);
    vectors++;
    if ({b.tx_null, b.tx_seqn} !== 2'b01) begin
      miscompares++;
      $display("FAIL ack_tx_start null/seqn got=%b exp=01", {b.tx_null, b.tx_seqn});
    end
    do_header(1'b1);
    do_endp();
    exp_q.push_back('{drop: 1'b0, s1a: 1'b0});
    do_hdr(1'b1, 1'b1);
    vectors++;
    if ({b.s1a, b.tx_seqn, b.txbuf_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL ack_after got=%b exp=0000", {b.s1a, b.tx_seqn, b.txbuf_valid});
    end
    end_test("ack");
  endtask
  task automatic test_back_to_back();
    do_reset(4'd0);
    do_load(10'd27);
    tick();
    do_header(1'b1);
    do_endp();
    b.bsm_load_p = 1'b1;
    b.bsm_len    = 10'd55;
    exp_q.push_back('{drop: 1'b0, s1a: 1'b0});
    do_hdr(1'b1, 1'b1);
    b.bsm_load_p = 1'b0;
    vectors++;
    if ({b.txbuf_valid, b.s1a, b.tx_seqn, b.load_err_p, b.tx_pylenByte} !== {5'b01000, 10'd55}) begin
      miscompares++;
      $display("FAIL b2b_load_ack got=%b exp=%b",
               {b.txbuf_valid, b.s1a, b.tx_seqn, b.load_err_p, b.tx_pylenByte}, {5'b01000, 10'd55});
    end
    do_header(1'b1);
    vectors++;
    if ({b.tx_null, b.tx_seqn} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_second_tx null/seqn got=%b exp=00", {b.tx_null, b.tx_seqn});
    end
    do_endp();
    exp_q.push_back('{drop: 1'b0, s1a: 1'b1});
    do_hdr(1'b1, 1'b1);
    vectors++;
    if ({b.s1a, b.tx_seqn, b.txbuf_valid} !== 4'b1100) begin
      miscompares++;
      $display("FAIL b2b_second_ack got=%b exp=1100", {b.s1a, b.tx_seqn, b.txbuf_valid});
    end
    end_test("b2b");
  endtask
  task automatic test_retx_limit();
    do_reset(4'd3);
    do_load(10'd40);
    tick();
    for (int k = 0; k < 3; k++) begin
      do_header(1'b1);
      vectors++;
      if ({b.tx_null, b.tx_seqn, b.s1a, b.tx_pylenByte} !== {3'b011, 10'd40}) begin
        miscompares++;
        $display("FAIL retx_resend_%0d got=%b exp=%b", k, {b.tx_null, b.tx_seqn, b.s1a, b.tx_pylenByte},
                 {3'b011, 10'd40});
      end
      do_endp();
      if (k == 2) exp_q.push_back('{drop: 1'b1, s1a: 1'b0});
      do_hdr(k != 1, 1'b0);
    end
    vectors++;
    if ({b.s1a, b.tx_seqn, b.txbuf_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL retx_drop_state got=%b exp=0000", {b.s1a, b.tx_seqn, b.txbuf_valid});
    end
    end_test("retx");
  endtask
  task automatic test_flow_stop();
    do_reset(4'd2);
    do_load(10'd12);
    tick();
    do_header(1'b0);
    vectors++;
    if (b.tx_null !== 1'b1) begin
      miscompares++;
      $display("FAIL flow_stop_null got=%b exp=1", b.tx_null);
    end
    do_header(1'b1);
    vectors++;
    if (b.tx_null !== 1'b0) begin
      miscompares++;
      $display("FAIL flow_go_null got=%b exp=0", b.tx_null);
    end
    do_endp();
    do_hdr(1'b1, 1'b0);
    vectors++;
    if ({b.s1a, b.tx_seqn, b.txbuf_valid} !== 4'b1110) begin
      miscompares++;
      $display("FAIL flow_first_nak got=%b exp=1110", {b.s1a, b.tx_seqn, b.txbuf_valid});
    end
    do_header(1'b1);
    do_endp();
    exp_q.push_back('{drop: 1'b1, s1a: 1'b0});
    do_hdr(1'b1, 1'b0);
    end_test("flow");
  endtask
  task automatic test_load_err();
    do_reset(4'd0);
    do_load(10'd27);
    vectors++;
    if (b.load_err_p !== 1'b0) begin
      miscompares++;
      $display("FAIL lderr_first got=%b exp=0", b.load_err_p);
    end
    do_load(10'd99);
    vectors++;
    if ({b.load_err_p, b.txbuf_valid, b.s1a, b.tx_pylenByte} !== {4'b1101, 10'd27}) begin
      miscompares++;
      $display("FAIL lderr_second got=%b exp=%b", {b.load_err_p, b.txbuf_valid, b.s1a, b.tx_pylenByte},
               {4'b1101, 10'd27});
    end
    tick();
    vectors++;
    if ({b.load_err_p, b.txbuf_valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL lderr_pulse_len got=%b exp=010", {b.load_err_p, b.txbuf_valid});
    end
    end_test("lderr");
  endtask
  task automatic test_flush();
    do_reset(4'd0);
    do_load(10'd30);
    tick();
    do_header(1'b1);
    do_endp();
    b.flush_p = 1'b1;
    do_hdr(1'b1, 1'b1);
    b.flush_p = 1'b0;
    vectors++;
    if ({b.txbuf_valid, b.s1a, b.tx_seqn, b.tx_null, b.bsm_wrrdy} !== 6'b001111) begin
      miscompares++;
      $display("FAIL flush_ack got=%b exp=001111",
               {b.txbuf_valid, b.s1a, b.tx_seqn, b.tx_null, b.bsm_wrrdy});
    end
    end_test("flush");
  endtask
  task automatic test_timeout();
    do_reset(4'd2);
    do_load(10'd33);
    tick();
    do_header(1'b1);
    do_endp();
    do_slot();
    do_slot();
    vectors++;
    if ({b.txbuf_valid, b.s1a, b.tx_seqn} !== 4'b1011) begin
      miscompares++;
      $display("FAIL timeout_nak got=%b exp=1011", {b.txbuf_valid, b.s1a, b.tx_seqn});
    end
    do_header(1'b1);
    vectors++;
    if ({b.tx_null, b.tx_seqn, b.tx_pylenByte} !== {2'b01, 10'd33}) begin
      miscompares++;
      $display("FAIL timeout_resend got=%b exp=%b", {b.tx_null, b.tx_seqn, b.tx_pylenByte},
               {2'b01, 10'd33});
    end
    do_endp();
    exp_q.push_back('{drop: 1'b1, s1a: 1'b0});
    do_hdr(1'b0, 1'b1);
    vectors++;
    if ({b.s1a, b.tx_seqn, b.txbuf_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL timeout_drop got=%b exp=0000", {b.s1a, b.tx_seqn, b.txbuf_valid});
    end
    end_test("timeout");
  endtask
  initial begin
    idle_inputs();
    b.regi_retx_limit = '0;
    test_reset();
    test_ack_flow();
    test_back_to_back();
    test_retx_limit();
    test_flow_stop();
    test_load_err();
    test_flush();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
